// File: rtl/mem_port_arbiter.sv
// Shared IF/D port onto one fixed-latency, single-ported word memory.
// One access in flight at a time; round-robin on ties.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              d_rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic LAT1 = (MEM_LAT == 1);

  state_t r_state;
  state_t w_next;

  logic              r_last_d;
  logic              r_owner_d;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_if_vld;
  logic              r_if_err;
  logic [DATA_W-1:0] r_if_data;
  logic              r_d_vld;
  logic              r_d_err;
  logic [DATA_W-1:0] r_d_data;

  logic              w_open;
  logic              w_gnt_if;
  logic              w_gnt_d;
  logic              w_accept;
  logic [ADDR_W-1:0] w_req_addr;
  logic              w_mis;
  logic              w_sample;

  assign w_open = (r_state == S_IDLE)
               || (r_state == S_RESP);

  // Ties go to whoever did not own the last access.
  always_comb begin
    w_gnt_if = 1'b0;
    w_gnt_d  = 1'b0;
    if (w_open) begin
      if (if_req_valid && d_req_valid) begin
        w_gnt_d  = !r_last_d;
        w_gnt_if = r_last_d;
      end else begin
        w_gnt_if = if_req_valid;
        w_gnt_d  = d_req_valid;
      end
    end
  end

  assign w_accept   = w_gnt_if | w_gnt_d;
  assign w_req_addr = w_gnt_d ? d_addr : if_addr;
  assign w_mis      = (w_req_addr[1:0] != 2'b00);

  // Last cycle in which mem_rdata is valid for this access.
  assign w_sample =
      ((r_state == S_ACCESS) && LAT1)
   || ((r_state == S_WAIT)
       && (r_cnt == CNT_W'(1)));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept)
          w_next = w_mis ? S_RESP : S_ACCESS;
        else
          w_next = S_IDLE;
      end
      S_ACCESS: w_next = LAT1 ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (r_cnt == CNT_W'(1))
          w_next = S_RESP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d  <= 1'b0;
      r_owner_d <= 1'b0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
    end else if (w_accept) begin
      r_last_d  <= w_gnt_d;
      r_owner_d <= w_gnt_d;
      r_addr    <= w_req_addr;
      r_we      <= w_gnt_d & d_we;
      r_wdata   <= w_gnt_d ? d_wdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (r_state == S_ACCESS)
      r_cnt <= CNT_W'(MEM_LAT - 1);
    else if (r_state == S_WAIT)
      r_cnt <= r_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_vld  <= 1'b0;
      r_if_err  <= 1'b0;
      r_if_data <= '0;
      r_d_vld   <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_data  <= '0;
    end else begin
      r_if_vld <= 1'b0;
      r_d_vld  <= 1'b0;
      if (w_sample) begin
        if (r_owner_d) begin
          r_d_vld  <= 1'b1;
          r_d_err  <= 1'b0;
          r_d_data <= r_we ? '0 : mem_rdata;
        end else begin
          r_if_vld  <= 1'b1;
          r_if_err  <= 1'b0;
          r_if_data <= mem_rdata;
        end
      end else if (w_accept && w_mis) begin
        if (w_gnt_d) begin
          r_d_vld  <= 1'b1;
          r_d_err  <= 1'b1;
          r_d_data <= '0;
        end else begin
          r_if_vld  <= 1'b1;
          r_if_err  <= 1'b1;
          r_if_data <= '0;
        end
      end
    end
  end

  assign if_req_ready = w_gnt_if;
  assign d_req_ready  = w_gnt_d;

  assign if_rsp_valid = r_if_vld;
  assign if_rsp_data  = r_if_data;
  assign if_rsp_err   = r_if_err;
  assign d_rsp_valid  = r_d_vld;
  assign d_rsp_data   = r_d_data;
  assign d_rsp_err    = r_d_err;

  assign mem_en    = (r_state == S_ACCESS);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reference model + scoreboard,
// directed cases followed by random IF/D traffic.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;
  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_addr;
  logic        d_we;
  logic [31:0] d_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LAT(LAT), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid),
    .if_req_ready(if_req_ready),
    .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid),
    .d_req_ready(d_req_ready),
    .d_addr(d_addr),
    .d_we(d_we),
    .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid),
    .d_rsp_data(d_rsp_data),
    .d_rsp_err(d_rsp_err),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    int          due;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mop_t;

  typedef struct {
    bit          gap;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit init_pulse;

  rsp_t ei[$];
  rsp_t ed[$];
  mop_t em[$];
  req_t iq[$];
  req_t dq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] seed(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h00402083;
  endfunction

  // Memory device: reads valid only in the exact sample cycle.
  logic [31:0] mem [64];
  logic [31:0] rd_word;
  int          rd_cnt;

  always @(posedge clk) begin
    if (init_pulse) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed(i);
      rd_cnt <= 0;
    end else if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr[7:2]] <= mem_wdata;
      end else begin
        rd_word <= mem[mem_addr[7:2]];
        rd_cnt  <= LAT - 1;
      end
    end else if (rd_cnt > 0) begin
      rd_cnt <= rd_cnt - 1;
    end
  end

  assign mem_rdata = (rd_cnt == 1) ? rd_word : 32'hDEADBEEF;

  // Reference model: arbitration, timing and memory contents.
  logic [31:0] ref_mem [64];
  int          m_free;
  bit          m_last_if;
  bit          gi, gd, mis, we;
  logic [31:0] a, dat;
  rsp_t        rr;
  mop_t        mo;

  always @(negedge clk) begin
    if (init_pulse)
      for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);
    if (!rst_n) begin
      m_free    = 0;
      m_last_if = 1'b1;
    end else begin
      gi = 1'b0;
      gd = 1'b0;
      if (cyc >= m_free) begin
        if (if_req_valid && d_req_valid) begin
          if (m_last_if) gd = 1'b1;
          else           gi = 1'b1;
        end else if (if_req_valid) gi = 1'b1;
        else if (d_req_valid)      gd = 1'b1;
      end
      chk("if_ready", if_req_ready, gi);
      chk("d_ready", d_req_ready, gd);
      if (gi || gd) begin
        a   = gi ? if_addr : d_addr;
        we  = gd && d_we;
        mis = (a % 4) != 0;
        dat = (mis || we) ? 32'h0 : ref_mem[a[7:2]];
        rr.due  = mis ? cyc + 1 : cyc + LAT + 1;
        rr.data = dat;
        rr.err  = mis;
        if (!mis) begin
          mo.due   = cyc + 1;
          mo.we    = we;
          mo.addr  = a;
          mo.wdata = d_wdata;
          em.push_back(mo);
          if (we) ref_mem[a[7:2]] = d_wdata;
        end
        m_free    = rr.due;
        m_last_if = gi;
        if (gi) ei.push_back(rr);
        else    ed.push_back(rr);
      end
    end
  end

  // Monitor: pops and compares whatever the DUT presents.
  logic [31:0] h_if_d, h_d_d;
  logic        h_if_e, h_d_e;
  rsp_t        pi, pd;
  mop_t        pm;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_if_vld", if_rsp_valid, 0);
      chk("rst_d_vld", d_rsp_valid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_if_data", if_rsp_data, 0);
      chk("rst_d_data", d_rsp_data, 0);
      ei.delete();
      ed.delete();
      em.delete();
      h_if_d = '0; h_if_e = 1'b0;
      h_d_d  = '0; h_d_e  = 1'b0;
    end else begin
      if (if_rsp_valid) begin
        if (ei.size() == 0) begin
          chk("if_rsp_unexpected", if_rsp_valid, 0);
        end else begin
          pi = ei.pop_front();
          chk("if_rsp_cycle", cyc, pi.due);
          chk("if_rsp_data", if_rsp_data, pi.data);
          chk("if_rsp_err", if_rsp_err, pi.err);
          h_if_d = pi.data;
          h_if_e = pi.err;
        end
      end else begin
        if (ei.size() > 0 && ei[0].due <= cyc) begin
          chk("if_rsp_missing", if_rsp_valid, 1);
          void'(ei.pop_front());
        end
        chk("if_hold_data", if_rsp_data, h_if_d);
        chk("if_hold_err", if_rsp_err, h_if_e);
      end
      if (d_rsp_valid) begin
        if (ed.size() == 0) begin
          chk("d_rsp_unexpected", d_rsp_valid, 0);
        end else begin
          pd = ed.pop_front();
          chk("d_rsp_cycle", cyc, pd.due);
          chk("d_rsp_data", d_rsp_data, pd.data);
          chk("d_rsp_err", d_rsp_err, pd.err);
          h_d_d = pd.data;
          h_d_e = pd.err;
        end
      end else begin
        if (ed.size() > 0 && ed[0].due <= cyc) begin
          chk("d_rsp_missing", d_rsp_valid, 1);
          void'(ed.pop_front());
        end
        chk("d_hold_data", d_rsp_data, h_d_d);
        chk("d_hold_err", d_rsp_err, h_d_e);
      end
      if (mem_en) begin
        if (em.size() == 0) begin
          chk("mem_en_unexpected", mem_en, 0);
        end else begin
          pm = em.pop_front();
          chk("mem_cycle", cyc, pm.due);
          chk("mem_we", mem_we, pm.we);
          chk("mem_addr", mem_addr, pm.addr);
          if (pm.we) chk("mem_wdata", mem_wdata, pm.wdata);
        end
      end else if (em.size() > 0 && em[0].due <= cyc) begin
        chk("mem_en_missing", mem_en, 1);
        void'(em.pop_front());
      end
    end
  end

  function automatic req_t mk(input logic [31:0] ad,
                              input logic w,
                              input logic [31:0] wd);
    req_t r;
    r.gap   = 1'b0;
    r.addr  = ad;
    r.we    = w;
    r.wdata = wd;
    return r;
  endfunction

  function automatic req_t rnd_req(input bit is_d);
    req_t r;
    r.gap   = ($urandom_range(0, 9) < 3);
    r.addr  = 32'($urandom_range(0, 63)) << 2;
    if ($urandom_range(0, 9) == 0)
      r.addr = r.addr | 32'($urandom_range(1, 3));
    r.we    = is_d && $urandom_range(0, 2) == 0;
    r.wdata = $urandom;
    return r;
  endfunction

  // Drives both queues, holding each request until accepted.
  task automatic run_seq();
    int k;
    bit hi, hd;
    k = 0;
    while ((iq.size() > 0 || dq.size() > 0) && k < 4000) begin
      if (iq.size() > 0 && iq[0].gap) begin
        if_req_valid = 1'b0;
        void'(iq.pop_front());
      end else if (iq.size() > 0) begin
        if_req_valid = 1'b1;
        if_addr      = iq[0].addr;
      end else begin
        if_req_valid = 1'b0;
      end
      if (dq.size() > 0 && dq[0].gap) begin
        d_req_valid = 1'b0;
        void'(dq.pop_front());
      end else if (dq.size() > 0) begin
        d_req_valid = 1'b1;
        d_addr      = dq[0].addr;
        d_we        = dq[0].we;
        d_wdata     = dq[0].wdata;
      end else begin
        d_req_valid = 1'b0;
      end
      @(negedge clk);
      hi = if_req_valid && if_req_ready;
      hd = d_req_valid && d_req_ready;
      @(posedge clk);
      #1;
      if (hi) void'(iq.pop_front());
      if (hd) void'(dq.pop_front());
      k++;
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    chk("seq_budget", 32'(k >= 4000), 0);
    for (int j = 0; j < 30 && (ei.size() + ed.size() + em.size()) > 0; j++) begin
      @(posedge clk);
      #1;
    end
    chk("drained", ei.size() + ed.size() + em.size(), 0);
  endtask

  initial begin
    int k;
    rst_n        = 1'b0;
    init_pulse   = 1'b1;
    if_req_valid = 1'b0;
    if_addr      = '0;
    d_req_valid  = 1'b0;
    d_addr       = '0;
    d_we         = 1'b0;
    d_wdata      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_mem_we", mem_we, 0);
    init_pulse = 1'b0;
    rst_n      = 1'b1;
    @(posedge clk);
    #1;

    iq.push_back(mk(32'd0, 1'b0, 32'd0));
    run_seq();
    chk("fetch0_word", if_rsp_data, 32'h00402083);

    iq.push_back(mk(32'd4, 1'b0, 32'd0));
    dq.push_back(mk(32'd8, 1'b0, 32'd0));
    run_seq();

    iq.push_back(mk(32'd0, 1'b0, 32'd0));
    iq.push_back(mk(32'd4, 1'b0, 32'd0));
    iq.push_back(mk(32'd8, 1'b0, 32'd0));
    run_seq();

    dq.push_back(mk(32'd12, 1'b1, 32'h0000000B));
    dq.push_back(mk(32'd12, 1'b0, 32'd0));
    run_seq();
    chk("store_load_12", d_rsp_data, 32'h0000000B);

    dq.push_back(mk(32'd6, 1'b0, 32'd0));
    run_seq();
    chk("mis_err", d_rsp_err, 1);

    // Reset while a D load sits in WAIT; then tie goes to D.
    d_req_valid = 1'b1;
    d_addr      = 32'd16;
    d_we        = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!d_req_ready && k < 20);
    chk("rst_case_accept", d_req_ready, 1);
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_mem_en", mem_en, 0);
    chk("async_d_vld", d_rsp_valid, 0);
    chk("async_d_err", d_rsp_err, 0);
    chk("async_mem_addr", mem_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    iq.push_back(mk(32'd20, 1'b0, 32'd0));
    dq.push_back(mk(32'd24, 1'b0, 32'd0));
    run_seq();

    for (int n = 0; n < 250; n++) begin
      iq.push_back(rnd_req(1'b0));
      dq.push_back(rnd_req(1'b1));
    end
    run_seq();

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
